// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : if_pkg                                                       |
// | Description : Shared constants for the instruction-fetch front end.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package if_pkg;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam int          STALL_PC         = 0;
    localparam int          STALL_IFID       = 1;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage : if_pkg
`default_nettype wire

// File: rtl/if_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_pc_reg                                                    |
// | Description : PC and ROM chip-enable register with flush/stall/branch      |
// |               redirect priority. Optional IF_ALIGN_CHECK_EN adds           |
// |               misaligned-target detection.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_pc_reg
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
`ifdef IF_ALIGN_CHECK_EN
    output logic              addr_err,
    output logic [ADDR_W-1:0] bad_vaddr,
`endif
    output logic              rom_ce,
    output logic [ADDR_W-1:0] pc
);

    logic              rom_ce_q;
    logic              rom_ce_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
`ifdef IF_ALIGN_CHECK_EN
    logic              addr_err_q;
    logic              addr_err_d;
    logic [ADDR_W-1:0] bad_vaddr_q;
    logic [ADDR_W-1:0] bad_vaddr_d;
`endif

    always_comb begin
        rom_ce_d    = 1'b1;
        pc_d        = pc_q;
        redirect    = 1'b0;
        redirect_pc = flush_pc;
        // Until the ROM is enabled the PC stays parked at RESET_PC.
        if (rom_ce_q) begin
            if (flush) begin
                redirect    = 1'b1;
                redirect_pc = flush_pc;
            end else if (!hold_pc) begin
                if (branch_flag) begin
                    redirect    = 1'b1;
                    redirect_pc = branch_target;
                end else begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
        end
`ifdef IF_ALIGN_CHECK_EN
        addr_err_d  = redirect && (redirect_pc[1:0] != 2'b00);
        bad_vaddr_d = addr_err_d ? redirect_pc : bad_vaddr_q;
        if (redirect) pc_d = redirect_pc & ~ADDR_W'(3);
`else
        if (redirect) pc_d = redirect_pc;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_ce_q <= 1'b0;
            pc_q     <= RESET_PC;
        end else begin
            rom_ce_q <= rom_ce_d;
            pc_q     <= pc_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_q  <= 1'b0;
            bad_vaddr_q <= '0;
        end else begin
            addr_err_q  <= addr_err_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign addr_err  = addr_err_q;
    assign bad_vaddr = bad_vaddr_q;
`endif

    assign rom_ce = rom_ce_q;
    assign pc     = pc_q;

endmodule : if_pc_reg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_fetch_unit                                                |
// | Description : Instruction-fetch front end: PC, ROM interface, IF/ID        |
// |               register and saturating fetch counter. Optional macro        |
// |               IF_ALIGN_CHECK_EN exposes addr_err / bad_vaddr.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_inst,
    output logic              id_valid,
`ifdef IF_ALIGN_CHECK_EN
    output logic              addr_err,
    output logic [ADDR_W-1:0] bad_vaddr,
`endif
    output logic [CNT_W-1:0]  fetch_cnt
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] id_pc_q;
    logic [ADDR_W-1:0] id_pc_d;
    logic [31:0]       id_inst_q;
    logic [31:0]       id_inst_d;
    logic              id_valid_q;
    logic              id_valid_d;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic [CNT_W-1:0]  fetch_cnt_d;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .hold_pc       (stall[STALL_PC]),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
`ifdef IF_ALIGN_CHECK_EN
        .addr_err      (addr_err),
        .bad_vaddr     (bad_vaddr),
`endif
        .rom_ce        (rom_ce),
        .pc            (pc)
    );

    always_comb begin
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        // A PC-only stall must bubble IF/ID, or decode would see the held
        // instruction twice.
        if (flush || (!stall[STALL_IFID] && stall[STALL_PC])) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (!stall[STALL_IFID]) begin
            id_pc_d    = pc;
            id_inst_d  = rom_inst;
            id_valid_d = rom_ce;
            if (rom_ce && !(&fetch_cnt_q)) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign rom_addr  = pc;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_valid  = id_valid_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_fetch_unit                                             |
// | Description : Directed self-checking bench for if_fetch_unit with a        |
// |               behavioural single-cycle ROM (honours IF_ALIGN_CHECK_EN).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_if_fetch_unit;

    localparam int CNT_W = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [CNT_W-1:0] fetch_cnt;
`ifdef IF_ALIGN_CHECK_EN
    logic        addr_err;
    logic [31:0] bad_vaddr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
`ifdef IF_ALIGN_CHECK_EN
        .addr_err      (addr_err),
        .bad_vaddr     (bad_vaddr),
`endif
        .fetch_cnt     (fetch_cnt)
    );

    // ROM content: a distinct word per word address, ignoring bits [1:0].
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {15'h0, a[18:2]};
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 2'b00; flush = 1'b0; flush_pc = '0;
        branch_flag = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", rom_ce); end
        n_checks++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", rom_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        n_checks++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", id_inst); end
        n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_idpc: got %h want 0", id_pc); end
        n_checks++; if (fetch_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", fetch_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        tick();
        n_checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin n_fail++; $display("FAIL seq_first: got ce=%b addr=%h want ce=1 addr=0", rom_ce, rom_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid0: got %b want 0", id_valid); end
        tick();
        n_checks++; if (rom_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr4: got %h want 4", rom_addr); end
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== rom_word(32'h0)) begin n_fail++; $display("FAIL seq_id0: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", id_valid, id_pc, id_inst, rom_word(32'h0)); end
        tick();
        n_checks++; if (rom_addr !== 32'h8 || id_pc !== 32'h4) begin n_fail++; $display("FAIL seq_addr8: got addr=%h idpc=%h want 8/4", rom_addr, id_pc); end
        tick();
        n_checks++; if (rom_addr !== 32'hC || id_pc !== 32'h8) begin n_fail++; $display("FAIL seq_addrC: got addr=%h idpc=%h want c/8", rom_addr, id_pc); end
        n_checks++; if (fetch_cnt !== 4'd3) begin n_fail++; $display("FAIL seq_cnt3: got %0d want 3", fetch_cnt); end
        tick();
        n_checks++; if (rom_addr !== 32'h10 || fetch_cnt !== 4'd4) begin n_fail++; $display("FAIL seq_addr10: got addr=%h cnt=%0d want 10/4", rom_addr, fetch_cnt); end
    endtask

    task automatic test_stall_pc();
        stall = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL stpc_hold%0d: got %h want 10", i, rom_addr); end
            n_checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL stpc_bubble%0d: got v=%b inst=%h pc=%h want 0/0/0", i, id_valid, id_inst, id_pc); end
        end
        n_checks++; if (fetch_cnt !== 4'd4) begin n_fail++; $display("FAIL stpc_cnt: got %0d want 4", fetch_cnt); end
        stall = 2'b00;
        tick();
        n_checks++; if (rom_addr !== 32'h14 || id_pc !== 32'h10 || id_valid !== 1'b1 || id_inst !== rom_word(32'h10)) begin n_fail++; $display("FAIL stpc_resume: got addr=%h idpc=%h v=%b inst=%h want 14/10/1/%h", rom_addr, id_pc, id_valid, id_inst, rom_word(32'h10)); end
        n_checks++; if (fetch_cnt !== 4'd5) begin n_fail++; $display("FAIL stpc_cnt5: got %0d want 5", fetch_cnt); end
    endtask

    task automatic test_stall_all();
        stall = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rom_addr !== 32'h14 || id_pc !== 32'h10 || id_valid !== 1'b1 || id_inst !== rom_word(32'h10) || fetch_cnt !== 4'd5) begin n_fail++; $display("FAIL stall_all%0d: got addr=%h idpc=%h v=%b inst=%h cnt=%0d want 14/10/1/%h/5", i, rom_addr, id_pc, id_valid, id_inst, fetch_cnt, rom_word(32'h10)); end
        end
        stall = 2'b00;
        repeat (3) tick();
        n_checks++; if (rom_addr !== 32'h20 || id_pc !== 32'h1C || fetch_cnt !== 4'd8) begin n_fail++; $display("FAIL stall_all_resume: got addr=%h idpc=%h cnt=%0d want 20/1c/8", rom_addr, id_pc, fetch_cnt); end
    endtask

    task automatic test_branch();
        branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        n_checks++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL br_target: got %h want 100", rom_addr); end
        n_checks++; if (id_pc !== 32'h20 || id_valid !== 1'b1 || id_inst !== rom_word(32'h20)) begin n_fail++; $display("FAIL br_delay_slot: got pc=%h v=%b inst=%h want 20/1/%h", id_pc, id_valid, id_inst, rom_word(32'h20)); end
        tick();
        n_checks++; if (rom_addr !== 32'h104 || id_pc !== 32'h100 || fetch_cnt !== 4'd10) begin n_fail++; $display("FAIL br_follow: got addr=%h idpc=%h cnt=%0d want 104/100/10", rom_addr, id_pc, fetch_cnt); end
        // Branch during a PC stall is dropped; the held flag takes effect after.
        branch_flag = 1'b1; branch_target = 32'h200; stall = 2'b01;
        tick();
        n_checks++; if (rom_addr !== 32'h104 || id_valid !== 1'b0) begin n_fail++; $display("FAIL br_stalled: got addr=%h v=%b want 104/0", rom_addr, id_valid); end
        stall = 2'b00;
        tick();
        branch_flag = 1'b0;
        n_checks++; if (rom_addr !== 32'h200 || id_pc !== 32'h104 || fetch_cnt !== 4'd11) begin n_fail++; $display("FAIL br_after_stall: got addr=%h idpc=%h cnt=%0d want 200/104/11", rom_addr, id_pc, fetch_cnt); end
    endtask

    task automatic test_flush();
        flush = 1'b1; flush_pc = 32'h180;
        branch_flag = 1'b1; branch_target = 32'h40; stall = 2'b11;
        tick();
        flush = 1'b0; branch_flag = 1'b0; stall = 2'b00;
        n_checks++; if (rom_addr !== 32'h180) begin n_fail++; $display("FAIL fl_target: got %h want 180", rom_addr); end
        n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || fetch_cnt !== 4'd11) begin n_fail++; $display("FAIL fl_clear: got v=%b pc=%h inst=%h cnt=%0d want 0/0/0/11", id_valid, id_pc, id_inst, fetch_cnt); end
        tick();
        n_checks++; if (rom_addr !== 32'h184 || id_pc !== 32'h180 || id_valid !== 1'b1 || fetch_cnt !== 4'd12) begin n_fail++; $display("FAIL fl_follow: got addr=%h idpc=%h v=%b cnt=%0d want 184/180/1/12", rom_addr, id_pc, id_valid, fetch_cnt); end
    endtask

    task automatic test_misaligned();
`ifdef IF_ALIGN_CHECK_EN
        n_checks++; if (addr_err !== 1'b0 || bad_vaddr !== 32'h0) begin n_fail++; $display("FAIL al_idle: got err=%b bad=%h want 0/0", addr_err, bad_vaddr); end
`endif
        branch_flag = 1'b1; branch_target = 32'h102;
        tick();
        branch_flag = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        n_checks++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL al_pc: got %h want 100", rom_addr); end
        n_checks++; if (addr_err !== 1'b1 || bad_vaddr !== 32'h102) begin n_fail++; $display("FAIL al_err: got err=%b bad=%h want 1/102", addr_err, bad_vaddr); end
`else
        n_checks++; if (rom_addr !== 32'h102) begin n_fail++; $display("FAIL al_pc: got %h want 102", rom_addr); end
`endif
        tick();
`ifdef IF_ALIGN_CHECK_EN
        n_checks++; if (addr_err !== 1'b0 || bad_vaddr !== 32'h102) begin n_fail++; $display("FAIL al_pulse: got err=%b bad=%h want 0/102", addr_err, bad_vaddr); end
        n_checks++; if (rom_addr !== 32'h104 || id_pc !== 32'h100) begin n_fail++; $display("FAIL al_follow: got addr=%h idpc=%h want 104/100", rom_addr, id_pc); end
`else
        n_checks++; if (rom_addr !== 32'h106 || id_pc !== 32'h102) begin n_fail++; $display("FAIL al_follow: got addr=%h idpc=%h want 106/102", rom_addr, id_pc); end
`endif
        n_checks++; if (id_inst !== rom_word(32'h100) || fetch_cnt !== 4'd14) begin n_fail++; $display("FAIL al_inst: got inst=%h cnt=%0d want %h/14", id_inst, fetch_cnt, rom_word(32'h100)); end
    endtask

    task automatic test_wrap_saturate();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        n_checks++; if (rom_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", rom_addr); end
        tick();
        n_checks++; if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_zero: got addr=%h idpc=%h want 0/fffffffc", rom_addr, id_pc); end
        n_checks++; if (fetch_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", fetch_cnt); end
        tick();
        n_checks++; if (fetch_cnt !== 4'd15 || rom_addr !== 32'h4) begin n_fail++; $display("FAIL sat_hold: got cnt=%0d addr=%h want 15/4", fetch_cnt, rom_addr); end
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #1;
        n_checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || fetch_cnt !== 4'd0) begin n_fail++; $display("FAIL async_rst: got ce=%b addr=%h v=%b idpc=%h cnt=%0d want all 0", rom_ce, rom_addr, id_valid, id_pc, fetch_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_pc();
        test_stall_all();
        test_branch();
        test_flush();
        test_misaligned();
        test_wrap_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_unit
`default_nettype wire
